// File: rtl/imm_op_sequencer_if.sv
// Handshake/control bundle between the immediate-op sequencer and its environment.
// The slave side is the sequencer; the master side drives start/mode/memory status.
interface imm_op_sequencer_if #(
  parameter int OPC_W = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic             run_mode;
  logic             halt_req;
  logic             mem_ready;
  logic [OPC_W-1:0] ir_opcode;
  logic [15:0]      ctrl;
  logic [1:0]       alu_op;
  logic [2:0]       state_o;
  logic             busy;
  logic             done;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] instr_count;

  // start is a level sampled each rising edge; it is acted on only while busy=0.
  // done/illegal/timeout are single-cycle pulses, one per instruction at most.
  modport master (
    output start, run_mode, halt_req, mem_ready, ir_opcode,
    input  ctrl, alu_op, state_o, busy, done, illegal, timeout, instr_count
  );

  modport slave (
    input  start, run_mode, halt_req, mem_ready, ir_opcode,
    output ctrl, alu_op, state_o, busy, done, illegal, timeout, instr_count
  );
endinterface

// File: rtl/imm_op_sequencer.sv
// Six-step control sequencer for immediate ALU instructions (ANDI/ORI/ADDI):
// fetch with bounded memory wait, decode, execute, write-back, optional continuous run.
module imm_op_sequencer #(
  parameter int               OPC_W       = 5,
  parameter int               CNT_W       = 16,
  parameter int               MEM_TIMEOUT = 15,
  parameter logic [OPC_W-1:0] OPC_ANDI    = 5'b01100,
  parameter logic [OPC_W-1:0] OPC_ORI     = 5'b01101,
  parameter logic [OPC_W-1:0] OPC_ADDI    = 5'b01011
) (
  input logic               Clock,
  input logic               Clear,
  imm_op_sequencer_if.slave bus
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam int B_PCOUT   = 0;
  localparam int B_MAR_EN  = 1;
  localparam int B_INCPC   = 2;
  localparam int B_ZLOWIN  = 3;
  localparam int B_ZLOWOUT = 4;
  localparam int B_PC_EN   = 5;
  localparam int B_MDR_RD  = 6;
  localparam int B_MDR_EN  = 7;
  localparam int B_MDROUT  = 8;
  localparam int B_IR_EN   = 9;
  localparam int B_GRB     = 10;
  localparam int B_R_OUT   = 11;
  localparam int B_Y_EN    = 12;
  localparam int B_COUT    = 13;
  localparam int B_GRA     = 14;
  localparam int B_R_IN    = 15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         alu_q, alu_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               op_legal;
  logic [1:0]         op_alu;
  logic [15:0]        ctrl;

  always_comb begin
    op_legal = 1'b1;
    op_alu   = 2'b00;
    if (bus.ir_opcode == OPC_ANDI) begin
      op_alu = 2'b00;
    end else if (bus.ir_opcode == OPC_ORI) begin
      op_alu = 2'b01;
    end else if (bus.ir_opcode == OPC_ADDI) begin
      op_alu = 2'b10;
    end else begin
      op_legal = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    alu_d     = alu_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        // wait_q holds the number of stalled T1 cycles already elapsed.
        if (bus.mem_ready) begin
          state_d = S_T2;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (op_legal) begin
          alu_d   = op_alu;
          state_d = S_T4;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5: begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (bus.run_mode && !bus.halt_req) ? S_T0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      alu_q     <= 2'b00;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      alu_q     <= alu_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // PC_enable in T1 follows mem_ready directly so the PC latches only on valid data.
  always_comb begin
    ctrl = 16'h0000;
    case (state_q)
      S_T0: begin
        ctrl[B_PCOUT]  = 1'b1;
        ctrl[B_MAR_EN] = 1'b1;
        ctrl[B_INCPC]  = 1'b1;
        ctrl[B_ZLOWIN] = 1'b1;
      end
      S_T1: begin
        ctrl[B_ZLOWOUT] = 1'b1;
        ctrl[B_PC_EN]   = bus.mem_ready;
        ctrl[B_MDR_RD]  = 1'b1;
        ctrl[B_MDR_EN]  = 1'b1;
      end
      S_T2: begin
        ctrl[B_MDROUT] = 1'b1;
        ctrl[B_IR_EN]  = 1'b1;
      end
      S_T3: begin
        ctrl[B_GRB]   = 1'b1;
        ctrl[B_R_OUT] = 1'b1;
        ctrl[B_Y_EN]  = 1'b1;
      end
      S_T4: begin
        ctrl[B_ZLOWIN] = 1'b1;
        ctrl[B_COUT]   = 1'b1;
      end
      S_T5: begin
        ctrl[B_ZLOWOUT] = 1'b1;
        ctrl[B_GRA]     = 1'b1;
        ctrl[B_R_IN]    = 1'b1;
      end
      default: ctrl = 16'h0000;
    endcase
  end

  assign bus.ctrl        = ctrl;
  assign bus.alu_op      = alu_q;
  assign bus.state_o     = state_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.timeout     = timeout_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_imm_op_sequencer.sv
// Self-checking bench for imm_op_sequencer: per-cycle {state,ctrl} and per-instruction
// event expectations are queued when stimulus is planned and popped as the DUT runs.
module tb_imm_op_sequencer;

  localparam int OPC_W = 5;
  localparam int CNT_W = 16;
  localparam int TO    = 15;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T0   = 3'd1;
  localparam logic [2:0] ST_T1   = 3'd2;
  localparam logic [2:0] ST_T2   = 3'd3;
  localparam logic [2:0] ST_T3   = 3'd4;
  localparam logic [2:0] ST_T4   = 3'd5;
  localparam logic [2:0] ST_T5   = 3'd6;

  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPC_W-1:0] OP_BAD  = 5'b11111;

  localparam logic [2:0] EV_DONE    = 3'b100;
  localparam logic [2:0] EV_ILLEGAL = 3'b010;
  localparam logic [2:0] EV_TIMEOUT = 3'b001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  imm_op_sequencer_if #(.OPC_W(OPC_W), .CNT_W(CNT_W)) bus();

  imm_op_sequencer #(
    .OPC_W(OPC_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TO)
  ) dut (
    .Clock(clk),
    .Clear(clear),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0]      exp_q[$];  // {state, ctrl} per busy cycle
  logic [20:0]      ev_q[$];   // {kind, alu_op, instr_count} per pulse
  logic [OPC_W-1:0] op_q[$];
  logic [1:0]       alu_m;
  logic [CNT_W-1:0] cnt_m;
  int  stall_cfg  = 0;
  int  halt_on_t2 = 0;
  int  t1_cnt     = 0;
  int  t2_seen    = 0;
  bit  halt_hold  = 1'b0;
  bit  mon_en     = 1'b0;
  logic [18:0] mon_e;
  logic [20:0] mon_ev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reactive driver (memory, IR, halt) ----------------
  always @(posedge clk) begin
    #1;
    if (bus.state_o == ST_T1) begin
      t1_cnt++;
      bus.mem_ready = (t1_cnt > stall_cfg);
    end else begin
      t1_cnt = 0;
      bus.mem_ready = 1'b0;
    end
    if (bus.state_o == ST_T0 && op_q.size() > 0) bus.ir_opcode = op_q.pop_front();
    if (bus.state_o == ST_T2) t2_seen++;
    bus.halt_req = halt_hold || (halt_on_t2 != 0 && t2_seen >= halt_on_t2);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.state_o != ST_IDLE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_busy", 32'(bus.state_o), 32'(ST_IDLE));
        end else begin
          mon_e = exp_q.pop_front();
          check("state", 32'(bus.state_o), 32'(mon_e[18:16]));
          check("ctrl", 32'(bus.ctrl), 32'(mon_e[15:0]));
          check("busy", 32'(bus.busy), 32'd1);
        end
      end else begin
        check("idle_ctrl", 32'(bus.ctrl), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
      end
      if (bus.done || bus.illegal || bus.timeout) begin
        if (ev_q.size() == 0) begin
          check("unexpected_event", 32'({bus.done, bus.illegal, bus.timeout}), 32'd0);
        end else begin
          mon_ev = ev_q.pop_front();
          check("event_kind", 32'({bus.done, bus.illegal, bus.timeout}), 32'(mon_ev[20:18]));
          check("event_alu", 32'(bus.alu_op), 32'(mon_ev[17:16]));
          check("event_cnt", 32'(bus.instr_count), 32'(mon_ev[15:0]));
        end
      end
    end
  end

  // ---------------- expectation model ----------------
  task automatic push_instr(input logic [OPC_W-1:0] op, input int stall, input bit cut_t4);
    op_q.push_back(op);
    exp_q.push_back({ST_T0, 16'h000F});
    for (int i = 0; i < stall && i < TO; i++) exp_q.push_back({ST_T1, 16'h00D0});
    if (stall >= TO) begin
      ev_q.push_back({EV_TIMEOUT, alu_m, cnt_m});
      return;
    end
    exp_q.push_back({ST_T1, 16'h00F0});
    exp_q.push_back({ST_T2, 16'h0300});
    exp_q.push_back({ST_T3, 16'h1C00});
    if (op == OP_ANDI)      alu_m = 2'b00;
    else if (op == OP_ORI)  alu_m = 2'b01;
    else if (op == OP_ADDI) alu_m = 2'b10;
    else begin
      ev_q.push_back({EV_ILLEGAL, alu_m, cnt_m});
      return;
    end
    exp_q.push_back({ST_T4, 16'h2008});
    if (cut_t4) return;
    exp_q.push_back({ST_T5, 16'hC010});
    cnt_m = cnt_m + 1'b1;
    ev_q.push_back({EV_DONE, alu_m, cnt_m});
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (k < 300 && !(exp_q.size() == 0 && bus.state_o == ST_IDLE)) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_reach_idle"}, 32'(k < 300), 32'd1);
    repeat (2) @(negedge clk);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_ev_left"}, 32'(ev_q.size()), 32'd0);
    check({tag, "_count"}, 32'(bus.instr_count), 32'(cnt_m));
    check({tag, "_alu"}, 32'(bus.alu_op), 32'(alu_m));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    alu_m = 2'b00;
    cnt_m = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    clear        = 1'b1;
    bus.start    = 1'b0;
    bus.run_mode = 1'b0;
    alu_m        = 2'b00;
    cnt_m        = '0;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    check("rst_state", 32'(bus.state_o), 32'(ST_IDLE));
    check("rst_ctrl", 32'(bus.ctrl), 32'd0);
    check("rst_alu", 32'(bus.alu_op), 32'd0);
    check("rst_flags", 32'({bus.busy, bus.done, bus.illegal, bus.timeout}), 32'd0);
    check("rst_count", 32'(bus.instr_count), 32'd0);
    mon_en = 1'b1;

    // single ANDI, memory ready immediately
    stall_cfg = 0;
    push_instr(OP_ANDI, 0, 1'b0);
    start_pulse();
    wait_idle("andi");

    // three stalled T1 cycles
    stall_cfg = 3;
    push_instr(OP_ORI, 3, 1'b0);
    start_pulse();
    wait_idle("stall3");

    // memory never ready: timeout after TO cycles
    stall_cfg = 100;
    push_instr(OP_ADDI, 100, 1'b0);
    start_pulse();
    wait_idle("timeout");

    // illegal opcode
    stall_cfg = 0;
    push_instr(OP_BAD, 0, 1'b0);
    start_pulse();
    wait_idle("illegal");

    // longest stall that still completes
    stall_cfg = TO - 1;
    push_instr(OP_ADDI, TO - 1, 1'b0);
    start_pulse();
    wait_idle("stall_max");

    // start while busy must be ignored
    stall_cfg = 3;
    push_instr(OP_ANDI, 3, 1'b0);
    start_pulse();
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("busy_start");

    // start with halt already high in continuous mode: exactly one instruction
    stall_cfg    = $urandom_range(0, 4);
    bus.run_mode = 1'b1;
    halt_hold    = 1'b1;
    @(negedge clk);
    push_instr(OP_ORI, stall_cfg, 1'b0);
    start_pulse();
    wait_idle("start_halt");
    halt_hold    = 1'b0;
    bus.run_mode = 1'b0;

    // Clear during T4, then restart on the following cycle
    stall_cfg = 0;
    push_instr(OP_ADDI, 0, 1'b1);
    start_pulse();
    k = 0;
    while (k < 50 && bus.state_o != ST_T4) begin
      @(negedge clk);
      k++;
    end
    check("reach_t4", 32'(bus.state_o), 32'(ST_T4));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    alu_m = 2'b00;
    cnt_m = '0;
    check("clr_state", 32'(bus.state_o), 32'(ST_IDLE));
    check("clr_ctrl", 32'(bus.ctrl), 32'd0);
    check("clr_count", 32'(bus.instr_count), 32'd0);
    check("clr_alu", 32'(bus.alu_op), 32'd0);
    check("clr_flags", 32'({bus.busy, bus.done, bus.illegal, bus.timeout}), 32'd0);
    check("clr_exp_left", 32'(exp_q.size()), 32'd0);
    push_instr(OP_ORI, 0, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("after_clr");

    // continuous ORI, ADDI, ANDI with halt raised in the third T2
    pulse_clear();
    stall_cfg    = 0;
    t2_seen      = 0;
    halt_on_t2   = 3;
    bus.run_mode = 1'b1;
    push_instr(OP_ORI, 0, 1'b0);
    push_instr(OP_ADDI, 0, 1'b0);
    push_instr(OP_ANDI, 0, 1'b0);
    start_pulse();
    wait_idle("cont");
    check("cont_count3", 32'(bus.instr_count), 32'd3);
    check("cont_state", 32'(bus.state_o), 32'(ST_IDLE));
    halt_on_t2   = 0;
    bus.run_mode = 1'b0;

    // random single instructions
    for (int i = 0; i < 6; i++) begin
      logic [OPC_W-1:0] op;
      int sel;
      sel = $urandom_range(0, 3);
      op  = (sel == 0) ? OP_ANDI : (sel == 1) ? OP_ORI : (sel == 2) ? OP_ADDI : OP_BAD;
      stall_cfg = $urandom_range(0, 6);
      push_instr(op, stall_cfg, 1'b0);
      start_pulse();
      wait_idle("rand");
    end

    check("op_left", 32'(op_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
